// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared mode and FSM state encodings for seq_shift_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational one-position shift/rotate step with carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  shift_mode_e      i_mode,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data,
    output logic             o_bit
);

    always_comb begin
        o_data = i_data;
        o_bit  = 1'b0;
        case (i_mode)
            SH_LSL: begin
                o_data = {i_data[WIDTH-2:0], i_fill};
                o_bit  = i_data[WIDTH-1];
            end
            SH_LSR: begin
                o_data = {i_fill, i_data[WIDTH-1:1]};
                o_bit  = i_data[0];
            end
            SH_ASR: begin
                o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
                o_bit  = i_data[0];
            end
            SH_ROR: begin
                o_data = {i_data[0], i_data[WIDTH-1:1]};
                o_bit  = i_data[0];
            end
            default: begin
                o_data = i_data;
                o_bit  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_unit
// Description : Multi-cycle serial shifter, one position per clock, with
//               valid/ready handshakes. SHIFT_SERIAL_IN_EN adds ser_in fill.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
`ifdef SHIFT_SERIAL_IN_EN
    input  logic             ser_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    localparam logic [AMT_W-1:0] c_one = AMT_W'(1);

    shift_state_e     r_state;
    shift_mode_e      r_mode;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_cout;

    logic [WIDTH-1:0] w_step_data;
    logic             w_step_bit;
    logic             w_fill;

`ifdef SHIFT_SERIAL_IN_EN
    assign w_fill = ser_in;
`else
    assign w_fill = 1'b0;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data (r_data),
        .i_mode (r_mode),
        .i_fill (w_fill),
        .o_data (w_step_data),
        .o_bit  (w_step_bit)
    );

    // Result registers are only loaded on entry to DONE so they hold outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= SH_LSL;
            r_data      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_data     <= in_data;
                        r_mode     <= shift_mode_e'(in_mode);
                        r_cnt      <= in_amt;
                        r_in_ready <= 1'b0;
                        if (in_amt != '0) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_data  <= in_data;
                            r_out_cout  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_step_data;
                    r_cnt  <= r_cnt - c_one;
                    if (r_cnt == c_one) begin
                        r_state     <= ST_DONE;
                        r_out_data  <= w_step_data;
                        r_out_cout  <= w_step_bit;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cout  = r_out_cout;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_unit
// Description : Directed plus randomized self-checking bench for seq_shift_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

    localparam int W     = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic             ser_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_cout;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(
        .WIDTH (W),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
`ifdef SHIFT_SERIAL_IN_EN
        .ser_in    (ser_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout)
    );

    // Closed-form result of shifting by the whole amount at once.
    function automatic void ref_model(input logic [W-1:0] d, input logic [1:0] m,
                                      input int amt, input logic f,
                                      output logic [W-1:0] r, output logic c);
        int k;
        r = d;
        c = 1'b0;
        if (amt != 0) begin
            case (m)
                2'b00: begin
                    r = d << amt;
                    if (f) r = r | ~(8'hFF << amt);
                    c = (amt <= W) ? d[W-amt] : f;
                end
                2'b01: begin
                    r = d >> amt;
                    if (f) r = r | ~(8'hFF >> amt);
                    c = (amt <= W) ? d[amt-1] : f;
                end
                2'b10: begin
                    r = (amt >= W) ? {W{d[W-1]}} : W'($signed(d) >>> amt);
                    c = (amt <= W) ? d[amt-1] : d[W-1];
                end
                default: begin
                    k = amt % W;
                    r = (k == 0) ? d : ((d >> k) | (d << (W - k)));
                    c = r[W-1];
                end
            endcase
        end
    endfunction

    task automatic run_op(input logic [W-1:0] d, input logic [1:0] m,
                          input logic [AMT_W-1:0] a, input logic f, input int hold);
        logic [W-1:0] er;
        logic         ec;
        int           n;
        ref_model(d, m, int'(a), f, er, ec);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_amt   = a;
        ser_in   = f;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready === 1'b1) passed++;
        else $error("FAIL ready_before_accept: observed %0h expected 1", in_ready);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        total++;
        if (in_ready === 1'b0) passed++;
        else $error("FAIL in_ready_busy: observed %0h expected 0", in_ready);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
            in_data = W'($urandom);
        end
        total++;
        if (n === int'(a) + 1) passed++;
        else $error("FAIL latency: observed %0d expected %0d", n, int'(a) + 1);
        total++;
        if (out_data === er) passed++;
        else $error("FAIL out_data: observed %0h expected %0h", out_data, er);
        total++;
        if (out_cout === ec) passed++;
        else $error("FAIL out_cout: observed %0h expected %0h", out_cout, ec);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'($urandom);
            in_amt   = AMT_W'($urandom);
            @(negedge clk);
            total++;
            if (out_valid === 1'b1) passed++;
            else $error("FAIL hold_valid: observed %0h expected 1", out_valid);
            total++;
            if (in_ready === 1'b0) passed++;
            else $error("FAIL hold_in_ready: observed %0h expected 0", in_ready);
            total++;
            if (out_data === er) passed++;
            else $error("FAIL hold_data: observed %0h expected %0h", out_data, er);
            total++;
            if (out_cout === ec) passed++;
            else $error("FAIL hold_cout: observed %0h expected %0h", out_cout, ec);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid === 1'b0) passed++;
        else $error("FAIL valid_drop: observed %0h expected 0", out_valid);
        total++;
        if (in_ready === 1'b1) passed++;
        else $error("FAIL idle_in_ready: observed %0h expected 1", in_ready);
        total++;
        if (out_data === er) passed++;
        else $error("FAIL data_held_idle: observed %0h expected %0h", out_data, er);
    endtask

    initial begin
        logic fr;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_amt    = '0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        #12;
        total++;
        if (in_ready === 1'b1) passed++;
        else $error("FAIL rst_in_ready: observed %0h expected 1", in_ready);
        total++;
        if (out_valid === 1'b0) passed++;
        else $error("FAIL rst_out_valid: observed %0h expected 0", out_valid);
        total++;
        if (out_data === 8'h00) passed++;
        else $error("FAIL rst_out_data: observed %0h expected 0", out_data);
        total++;
        if (out_cout === 1'b0) passed++;
        else $error("FAIL rst_out_cout: observed %0h expected 0", out_cout);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'b11111101, 2'b01, 4'd1, 1'b0, 0);
        run_op(8'b10001110, 2'b00, 4'd3, 1'b0, 0);
        run_op(8'b11001101, 2'b10, 4'd2, 1'b0, 0);
        run_op(8'b10001111, 2'b11, 4'd4, 1'b0, 0);
        for (int m = 0; m < 4; m++) run_op(8'hA5, 2'(m), 4'd0, 1'b0, 0);
        run_op(8'hFF, 2'b01, 4'd9, 1'b0, 0);
        run_op(8'h96, 2'b10, 4'd15, 1'b0, 0);
        run_op(8'h96, 2'b11, 4'd11, 1'b0, 0);
        run_op(8'h3C, 2'b00, 4'd8, 1'b0, 5);
`ifdef SHIFT_SERIAL_IN_EN
        run_op(8'h00, 2'b00, 4'd3, 1'b1, 0);
        run_op(8'h00, 2'b01, 4'd2, 1'b1, 0);
`endif
        run_op(8'hA5, 2'b00, 4'd0, 1'b0, 0);

        // Abort a long LSL mid-shift with reset.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h81;
        in_mode  = 2'b00;
        in_amt   = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready === 1'b1) passed++;
        else $error("FAIL abort_in_ready: observed %0h expected 1", in_ready);
        total++;
        if (out_valid === 1'b0) passed++;
        else $error("FAIL abort_out_valid: observed %0h expected 0", out_valid);
        total++;
        if (out_data === 8'h00) passed++;
        else $error("FAIL abort_out_data: observed %0h expected 0", out_data);
        total++;
        if (out_cout === 1'b0) passed++;
        else $error("FAIL abort_out_cout: observed %0h expected 0", out_cout);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h81, 2'b00, 4'd7, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
`ifdef SHIFT_SERIAL_IN_EN
            fr = 1'($urandom);
`else
            fr = 1'b0;
`endif
            run_op(W'($urandom), 2'($urandom), AMT_W'($urandom), fr,
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
